uart_byte_tx: RTL and testbench
===============================

UART_BYTE_TX -- requirements
Module: uart_byte_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 2320, gives clk_raw cycles per UART bit; legal range 2..4095.
REQ-002 clk_raw  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 data  input  8  byte to send; sampled only on acceptance.
REQ-005 tsent  input  1  send request, level, held high by upstream until trecieve seen.
REQ-006 trecieve  output  1  frame-complete acknowledge, level.
REQ-007 tx  output  1  serial line, idle high, 8N1 frame.
REQ-008 busy  output  1  high from acceptance until return to IDLE.

Function
REQ-009 States SHALL be IDLE, START, DATA, PARITY (present only per REQ-024), STOP, DONE.
REQ-010 In IDLE with tsent=1 at edge N, the block SHALL latch data into a shift register, enter START, drive tx=0 and busy=1 from edge N.
REQ-011 Each bit (start, 8 data, stop) SHALL hold tx for exactly CLKS_PER_BIT cycles, timed by a counter restarted at every bit boundary.
REQ-012 Data bits SHALL be sent LSB first; bit index counter SHALL be 3 bits and wrap 7->0 only on the DATA->next-state transition.
REQ-013 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles, then enter DONE with trecieve=1.
REQ-014 Frame length from acceptance to DONE entry SHALL be 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).
REQ-015 In DONE, trecieve SHALL stay 1 while tsent=1; on first cycle tsent=0 the block SHALL return to IDLE with trecieve=0, busy=0.
REQ-016 If tsent already 0 on DONE entry, trecieve SHALL be high exactly one cycle.
REQ-017 tsent dropping mid-frame SHALL NOT abort the frame; data changes mid-frame SHALL be ignored.
REQ-018 A new frame SHALL NOT start until one IDLE cycle has elapsed after DONE (guarantees four-phase handshake; no back-to-back without tsent low).
REQ-019 tx SHALL be a registered output (glitch-free).

Reset
REQ-020 rst_n=0 SHALL immediately force state IDLE, tx=1, trecieve=0, busy=0, counters and shift register zero.
REQ-021 Reset mid-frame SHALL abandon the frame; no acknowledge SHALL be produced for it.
REQ-022 After rst_n release, the first acceptance SHALL require tsent sampled high on a clk_raw edge.

Configuration
REQ-023 Macro UART_TX_PARITY_EN SHALL select parity support.
REQ-024 Defined: PARITY state between DATA and STOP sends even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Undefined: no PARITY state; DATA proceeds straight to STOP; frame 10 bits.

Structure
REQ-025 Package uart_pkg SHALL hold the state enum, default CLKS_PER_BIT, DATA_BITS=8, and frame-length constants for both configurations.
REQ-026 Sub-module uart_baud_tick (restartable down-counter emitting one-cycle bit_done) SHALL provide bit timing.

Verification (CLKS_PER_BIT=4)
REQ-027 data=0x41, tsent held high -> tx = 0,1,0,0,0,0,0,1,0,1 each 4 cycles; trecieve rises cycle 40 after acceptance.
REQ-028 tsent high then dropped after trecieve -> trecieve falls and busy=0 the next cycle; tx stays 1.
REQ-029 tsent pulsed one cycle, data changed to 0xFF mid-frame -> 0x41 frame still sent intact; trecieve high exactly one cycle.
REQ-030 rst_n asserted during bit 3 -> tx=1, busy=0 same cycle, no trecieve; next request sends full frame.
REQ-031 UART_TX_PARITY_EN defined, data=0x42 -> parity bit 0, data=0x43 -> parity bit 1; trecieve at cycle 44.
REQ-032 tsent held high across two DONE->IDLE attempts -> only one frame transmitted until tsent goes low.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART byte transmitter.
// Parity support is selected in the transmitter by the UART_TX_PARITY_EN macro.
package uart_pkg;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 2320;
    localparam int unsigned DATA_BITS            = 8;
    localparam int unsigned FRAME_BITS_NO_PARITY = DATA_BITS + 2;
    localparam int unsigned FRAME_BITS_PARITY    = DATA_BITS + 3;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StDone
    } tx_state_e;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Restartable bit-period down-counter; bit_done_o pulses on the last cycle of each bit.
module uart_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk_raw,
    input  logic rst_n,
    input  logic en_i,
    input  logic restart_i,
    output logic bit_done_o
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] Reload = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = Reload;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_raw or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_done_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/uart_byte_tx.sv
// 8N1 UART byte transmitter with a four-phase tsent/trecieve handshake.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 clk_raw,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 tsent,
    output logic                 trecieve,
    output logic                 tx,
    output logic                 busy
);

    tx_state_e            state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [2:0]           bit_idx_q;
    logic                 tx_q;
    logic                 busy_q;
    logic                 trecieve_q;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q;
`endif

    logic accept;
    logic timing;
    logic restart;
    logic bit_done;

    always_comb begin
        accept  = (state_q == StIdle) && tsent;
        timing  = (state_q == StStart) || (state_q == StData) ||
                  (state_q == StParity) || (state_q == StStop);
        // Reload the bit timer on acceptance and at every bit boundary.
        restart = accept || bit_done;
    end

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk_raw    (clk_raw),
        .rst_n      (rst_n),
        .en_i       (timing),
        .restart_i  (restart),
        .bit_done_o (bit_done)
    );

    always_ff @(posedge clk_raw or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            trecieve_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (tsent) begin
                        shift_q   <= data;
                        bit_idx_q <= '0;
                        tx_q      <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= StStart;
`ifdef UART_TX_PARITY_EN
                        parity_q  <= even_parity(data);
`endif
                    end
                end
                StStart: begin
                    if (bit_done) begin
                        tx_q    <= shift_q[0];
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (bit_done) begin
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= StParity;
`else
                            tx_q    <= 1'b1;
                            state_q <= StStop;
`endif
                        end else begin
                            shift_q <= {1'b0, shift_q[DATA_BITS-1:1]};
                            tx_q    <= shift_q[1];
                        end
                    end
                end
                StParity: begin
                    if (bit_done) begin
                        tx_q    <= 1'b1;
                        state_q <= StStop;
                    end
                end
                StStop: begin
                    if (bit_done) begin
                        trecieve_q <= 1'b1;
                        state_q    <= StDone;
                    end
                end
                StDone: begin
                    // Hold the acknowledge until upstream drops its request.
                    if (!tsent) begin
                        trecieve_q <= 1'b0;
                        busy_q     <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign trecieve = trecieve_q;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Directed self-checking bench for uart_byte_tx at CLKS_PER_BIT=4.
// Also exercises the parity frame when UART_TX_PARITY_EN is defined.
module tb_uart_byte_tx;

    localparam int unsigned Cpb = 4;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned FrameBits = 11;
`else
    localparam int unsigned FrameBits = 10;
`endif

    logic       clk_raw = 1'b0;
    logic       rst_n   = 1'b1;
    logic [7:0] data    = 8'h00;
    logic       tsent   = 1'b0;
    logic       trecieve;
    logic       tx;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_raw = ~clk_raw;

    uart_byte_tx #(
        .CLKS_PER_BIT(Cpb)
    ) dut (
        .clk_raw  (clk_raw),
        .rst_n    (rst_n),
        .data     (data),
        .tsent    (tsent),
        .trecieve (trecieve),
        .tx       (tx),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_raw);
        #1;
    endtask

    // Starts a frame from IDLE and checks every cycle of it up to DONE entry.
    // With pulse set, tsent drops and data is corrupted right after acceptance.
    task automatic send_frame(input string tag, input logic [7:0] b, input logic par,
                              input bit pulse);
        logic exp_bits [0:10];
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_bits[i+1] = b[i];
        end
`ifdef UART_TX_PARITY_EN
        exp_bits[9]  = par;
`else
        exp_bits[9]  = 1'b1;
`endif
        exp_bits[10] = 1'b1;

        data  = b;
        tsent = 1'b1;
        tick();
        check($sformatf("%s_busy_acc", tag), 32'(busy), 32'd1);
        if (pulse) begin
            tsent = 1'b0;
            data  = 8'hFF;
        end
        for (int i = 0; i < int'(FrameBits); i++) begin
            for (int c = 0; c < int'(Cpb); c++) begin
                check($sformatf("%s_bit%0d_c%0d", tag, i, c), 32'(tx), 32'(exp_bits[i]));
                if (c == 0) begin
                    check($sformatf("%s_ack_early%0d", tag, i), 32'(trecieve), 32'd0);
                end
                tick();
            end
        end
        check($sformatf("%s_ack", tag), 32'(trecieve), 32'd1);
        check($sformatf("%s_busy_done", tag), 32'(busy), 32'd1);
        check($sformatf("%s_tx_done", tag), 32'(tx), 32'd1);
        if (pulse) begin
            tick();
            check($sformatf("%s_ack_1cyc", tag), 32'(trecieve), 32'd0);
            check($sformatf("%s_busy_idle", tag), 32'(busy), 32'd0);
            check($sformatf("%s_tx_idle", tag), 32'(tx), 32'd1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        #2;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ack", 32'(trecieve), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_tx", 32'(tx), 32'd1);

        // 0x41 with tsent held high; DONE must not restart while the request stays up.
        send_frame("f41", 8'h41, 1'b0, 1'b0);
        for (int k = 0; k < int'(2 * FrameBits * Cpb); k++) begin
            tick();
            check($sformatf("hold_ack%0d", k), 32'(trecieve), 32'd1);
            check($sformatf("hold_tx%0d", k), 32'(tx), 32'd1);
            check($sformatf("hold_busy%0d", k), 32'(busy), 32'd1);
        end
        tsent = 1'b0;
        tick();
        check("drop_ack", 32'(trecieve), 32'd0);
        check("drop_busy", 32'(busy), 32'd0);
        check("drop_tx", 32'(tx), 32'd1);

        // One-cycle request, data corrupted mid-frame.
        tick();
        send_frame("pulse41", 8'h41, 1'b0, 1'b1);

        // Reset during frame bit 3.
        tick();
        data  = 8'hA5;
        tsent = 1'b1;
        tick();
        tsent = 1'b0;
        repeat (3 * Cpb) tick();
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ack", 32'(trecieve), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < int'(12 * Cpb); k++) begin
            tick();
            check($sformatf("postrst_ack%0d", k), 32'(trecieve), 32'd0);
            check($sformatf("postrst_busy%0d", k), 32'(busy), 32'd0);
            check($sformatf("postrst_tx%0d", k), 32'(tx), 32'd1);
        end
        send_frame("after_rst", 8'hA5, 1'b0, 1'b1);

`ifdef UART_TX_PARITY_EN
        tick();
        send_frame("par42", 8'h42, 1'b0, 1'b1);
        tick();
        send_frame("par43", 8'h43, 1'b1, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
